// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
package hazard_pkg;

  localparam int NREG       = 16;
  localparam int AW         = 4;
  localparam int CW         = 32;
  localparam int WDOG_LIMIT = 64;
  localparam int WDW        = $clog2(WDOG_LIMIT + 1);

  localparam logic [AW-1:0] PC_REG = AW'(15);

  // One in-flight destination tracker per pipeline stage (E/M/W).
  typedef struct packed {
    logic          v;
    logic [AW-1:0] dst;
  } slot_t;

  // One-hot of a slot's destination, or zero when the slot is empty.
  function automatic logic [NREG-1:0] slot_onehot(input slot_t s);
    logic [NREG-1:0] oh;
    oh = '0;
    if (s.v) oh[s.dst] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
  parameter int             W   = 8,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Count up while enabled, park at MAX, clear on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 q <= '0;
    else if (clr)               q <= '0;
    else if (en && (q != MAX))  q <= q + W'(1);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard scoreboard: tracks E/M/W destinations, stalls
// fetch/decode, injects bubbles into E, applies branch kills, and keeps
// stall statistics plus a frozen-pipeline watchdog.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid_d,
  input  logic [AW-1:0]   ra1_d,
  input  logic            ra1_used,
  input  logic [AW-1:0]   ra2_d,
  input  logic            ra2_used,
  input  logic [AW-1:0]   wa_d,
  input  logic            regwrite_d,
  input  logic            branch_kill,
  input  logic            mem_busy,
  input  logic            stat_clr,
  output logic            stall_f,
  output logic            stall_d,
  output logic            bubble_e,
  output logic [NREG-1:0] pending_mask,
  output logic [CW-1:0]   stall_cycles,
  output logic            watchdog_err
);

  localparam logic [WDW-1:0] WD_MAX  = WDW'(WDOG_LIMIT);
  localparam logic [WDW-1:0] WD_TRIP = WDW'(WDOG_LIMIT - 1);

  slot_t          e_q, m_q, w_q;
  logic           hazard;
  logic           issue;
  logic           hz_count;
  logic [WDW-1:0] wd_cnt;

  // W is excluded: the register file writes through, so a writeback and a
  // same-cycle read of that register see the new value.
  function automatic logic match(input slot_t e, input slot_t m, input logic [AW-1:0] r);
    return (e.v && (e.dst == r)) || (m.v && (m.dst == r));
  endfunction

  // Hazard detection and stall/bubble steering; mem_busy overrides all.
  always_comb begin
    hazard = instr_valid_d &&
             ((ra1_used && (ra1_d != PC_REG) && match(e_q, m_q, ra1_d)) ||
              (ra2_used && (ra2_d != PC_REG) && match(e_q, m_q, ra2_d)));
    issue    = instr_valid_d && regwrite_d && !hazard && !branch_kill;
    hz_count = hazard && !branch_kill && !mem_busy;
    // Outputs are forced quiet while reset is asserted, whatever mem_busy does.
    stall_f  = rst_n && (mem_busy || (hazard && !branch_kill));
    stall_d  = stall_f;
    bubble_e = rst_n && !mem_busy && (hazard || branch_kill);
  end

  // Pending-write mask across every valid in-flight slot.
  always_comb begin
    pending_mask = slot_onehot(e_q) | slot_onehot(m_q) | slot_onehot(w_q);
  end

  // Advance the E/M/W trackers unless memory has frozen the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else if (!mem_busy) begin
      w_q <= m_q;
      m_q <= e_q;
      e_q <= '{v: issue, dst: wa_d};
    end
  end

  sat_counter #(
    .W   (CW),
    .MAX ({CW{1'b1}})
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hz_count),
    .clr   (stat_clr),
    .q     (stall_cycles)
  );

  sat_counter #(
    .W   (WDW),
    .MAX (WD_MAX)
  ) u_wdog_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_f),
    .clr   (!stall_f),
    .q     (wd_cnt)
  );

  // Sticky error raised on the edge that brings the run length to the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               watchdog_err <= 1'b0;
    else if (stall_f && (wd_cnt >= WD_TRIP))  watchdog_err <= 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector bench for hazard_scoreboard.
module tb_hazard_scoreboard;

  logic        clk, rst_n;
  logic        instr_valid_d, ra1_used, ra2_used, regwrite_d;
  logic        branch_kill, mem_busy, stat_clr;
  logic [3:0]  ra1_d, ra2_d, wa_d;
  logic        stall_f, stall_d, bubble_e, watchdog_err;
  logic [15:0] pending_mask;
  logic [31:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  hazard_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid_d (instr_valid_d),
    .ra1_d         (ra1_d),
    .ra1_used      (ra1_used),
    .ra2_d         (ra2_d),
    .ra2_used      (ra2_used),
    .wa_d          (wa_d),
    .regwrite_d    (regwrite_d),
    .branch_kill   (branch_kill),
    .mem_busy      (mem_busy),
    .stat_clr      (stat_clr),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .bubble_e      (bubble_e),
    .pending_mask  (pending_mask),
    .stall_cycles  (stall_cycles),
    .watchdog_err  (watchdog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [3:0]  ra1;
    logic        u1;
    logic [3:0]  ra2;
    logic        u2;
    logic [3:0]  wa;
    logic        rw;
    logic        bk;
    logic        mb;
    logic        clr;
    logic        es;
    logic        eb;
    logic [15:0] epm;
    logic [31:0] esc;
  } vec_t;

  vec_t vt[25];

  function automatic vec_t mk(input logic iv, input logic [3:0] ra1, input logic u1,
                              input logic [3:0] ra2, input logic u2, input logic [3:0] wa,
                              input logic rw, input logic bk, input logic mb, input logic clr,
                              input logic es, input logic eb, input logic [15:0] epm,
                              input logic [31:0] esc);
    vec_t v;
    v.iv = iv; v.ra1 = ra1; v.u1 = u1; v.ra2 = ra2; v.u2 = u2; v.wa = wa;
    v.rw = rw; v.bk = bk; v.mb = mb; v.clr = clr;
    v.es = es; v.eb = eb; v.epm = epm; v.esc = esc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    instr_valid_d = v.iv; ra1_d = v.ra1; ra1_used = v.u1; ra2_d = v.ra2; ra2_used = v.u2;
    wa_d = v.wa; regwrite_d = v.rw; branch_kill = v.bk; mem_busy = v.mb; stat_clr = v.clr;
  endtask

  task automatic idle_inputs();
    instr_valid_d = 0; ra1_d = 0; ra1_used = 0; ra2_d = 0; ra2_used = 0;
    wa_d = 0; regwrite_d = 0; branch_kill = 0; mem_busy = 0; stat_clr = 0;
  endtask

  initial begin
    //           iv ra1 u1 ra2 u2 wa rw bk mb clr  es eb  pm        sc
    vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 16'h0000, 0);
    vt[1]  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,   0, 0, 16'h0000, 0);
    vt[2]  = mk(1, 3, 1, 0, 0, 9, 1, 0, 0, 0,   1, 1, 16'h0008, 0);
    vt[3]  = mk(1, 3, 1, 0, 0, 9, 1, 0, 0, 0,   1, 1, 16'h0008, 1);
    vt[4]  = mk(1, 3, 1, 0, 0, 9, 1, 0, 0, 0,   0, 0, 16'h0008, 2);
    vt[5]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   0, 0, 16'h0200, 2);
    vt[6]  = mk(1, 0, 0, 0, 0, 15, 1, 0, 0, 0,  0, 0, 16'h0220, 2);
    vt[7]  = mk(1, 9, 1, 15, 1, 0, 0, 0, 0, 0,  0, 0, 16'h8220, 2);
    vt[8]  = mk(1, 5, 1, 0, 0, 4, 1, 0, 0, 0,   0, 0, 16'h8020, 2);
    vt[9]  = mk(1, 4, 1, 0, 0, 6, 1, 1, 0, 0,   0, 1, 16'h8010, 2);
    vt[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 16'h0010, 2);
    vt[11] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,   0, 0, 16'h0010, 2);
    for (int i = 12; i <= 16; i++)
      vt[i] = mk(1, 7, 1, 0, 0, 2, 1, 0, 1, 0,  1, 0, 16'h0080, 2);
    for (int i = 17; i <= 19; i++)
      vt[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 16'h0080, 2);
    vt[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 16'h0000, 2);
    vt[21] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 0, 16'h0000, 2);
    vt[22] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 1,   1, 1, 16'h0002, 2);
    vt[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 16'h0002, 0);
    vt[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 16'h0002, 0);

    rst_n = 1'b0;
    idle_inputs();
    #12 rst_n = 1'b1;
    #1;
    chk("reset pending_mask", 32'(pending_mask), 0);
    chk("reset stall_cycles", stall_cycles, 0);
    chk("reset watchdog_err", 32'(watchdog_err), 0);
    chk("reset stall_f", 32'(stall_f), 0);

    // Table: one vector per cycle, sampled mid-low-phase before the edge.
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #2;
      chk($sformatf("v%0d stall_f", i), 32'(stall_f), 32'(vt[i].es));
      chk($sformatf("v%0d stall_d", i), 32'(stall_d), 32'(vt[i].es));
      chk($sformatf("v%0d bubble_e", i), 32'(bubble_e), 32'(vt[i].eb));
      chk($sformatf("v%0d pending_mask", i), 32'(pending_mask), 32'(vt[i].epm));
      chk($sformatf("v%0d stall_cycles", i), stall_cycles, vt[i].esc);
      chk($sformatf("v%0d watchdog_err", i), 32'(watchdog_err), 0);
    end

    // Watchdog: 63 frozen edges stay quiet, the 64th trips, and it sticks.
    @(negedge clk);
    idle_inputs();
    mem_busy = 1'b1;
    repeat (63) @(posedge clk);
    #1;
    chk("wdog after 63", 32'(watchdog_err), 0);
    @(posedge clk);
    #1;
    chk("wdog after 64", 32'(watchdog_err), 1);
    chk("wdog stall_cycles", stall_cycles, 0);
    @(negedge clk);
    mem_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("wdog sticky", 32'(watchdog_err), 1);
    chk("wdog stall_f low", 32'(stall_f), 0);

    // Reset mid-operation with live slots and a nonzero stall count.
    @(negedge clk);
    idle_inputs();
    instr_valid_d = 1; wa_d = 2; regwrite_d = 1;
    @(negedge clk);
    instr_valid_d = 1; ra1_d = 2; ra1_used = 1; wa_d = 8; regwrite_d = 1;
    #1;
    chk("pre-reset hazard", 32'(stall_f), 1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("pre-reset pending", 32'(pending_mask), 32'h0004);
    chk("pre-reset stall_cycles", stall_cycles, 1);
    mem_busy = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("in-reset pending", 32'(pending_mask), 0);
    chk("in-reset stall_cycles", stall_cycles, 0);
    chk("in-reset watchdog_err", 32'(watchdog_err), 0);
    chk("in-reset stall_f", 32'(stall_f), 0);
    chk("in-reset bubble_e", 32'(bubble_e), 0);
    #1;
    rst_n = 1'b1;
    mem_busy = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset pending", 32'(pending_mask), 0);
    chk("post-reset watchdog_err", 32'(watchdog_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
